// File: rtl/risc_program_counter.sv
`default_nettype none
// ============================================================================
//  Module   : risc_program_counter
//  Purpose  : Instruction address register for the RISC core. Once per rising
//             clock edge the address is reset, loaded with a branch target,
//             incremented by one, or held, in that priority order.
//  Ports    :
//    clk          in   1           system clock, rising-edge active
//    rst          in   1           synchronous active-high reset
//    inc          in   1           advance address by one (lowest priority)
//    branch_en    in   1           load branch_addr (overrides inc)
//    branch_addr  in   ADDR_WIDTH  absolute branch target, loaded verbatim
//    current_addr out  ADDR_WIDTH  current program address (register output)
//  Revision : 1.0  initial release
// ============================================================================
module risc_program_counter #(
    parameter int ADDR_WIDTH = 11,
    parameter int RESET_ADDR = 0
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  inc,
    input  wire logic                  branch_en,
    input  wire logic [ADDR_WIDTH-1:0] branch_addr,
    output logic      [ADDR_WIDTH-1:0] current_addr
);

    localparam logic [ADDR_WIDTH-1:0] c_reset_addr = RESET_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] c_one        = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Refuse to elaborate with a reset address that would be silently truncated.
    generate
        if ((RESET_ADDR < 0) || (RESET_ADDR >= (1 << ADDR_WIDTH))) begin : g_reset_addr_check
            $error("risc_program_counter: RESET_ADDR does not fit in ADDR_WIDTH bits");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_inc;

    // Natural width of the sum drops the carry, giving the 2^ADDR_WIDTH wrap.
    assign w_addr_inc = r_addr + c_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= c_reset_addr;
        end else if (branch_en) begin
            // Target is taken exactly; a concurrent inc is ignored.
            r_addr <= branch_addr;
        end else if (inc) begin
            r_addr <= w_addr_inc;
        end
    end

    // Fetch stage sees the register directly; no input-to-output path.
    assign current_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_risc_program_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_program_counter
//  Purpose  : Self-checking bench for risc_program_counter. A behavioural
//             model tracks the expected address as an integer; a compare
//             process checks the DUT against it on every falling edge after
//             the first reset, and directed steps check literal addresses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_risc_program_counter;

    localparam int ADDR_WIDTH = 11;
    localparam int ADDR_SPAN  = 1 << ADDR_WIDTH;

    logic                  clk;
    logic                  rst;
    logic                  inc;
    logic                  branch_en;
    logic [ADDR_WIDTH-1:0] branch_addr;
    logic [ADDR_WIDTH-1:0] current_addr;

    int checks;
    int errors;
    int model_addr;
    bit model_valid;

    risc_program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_ADDR (0)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .inc          (inc),
        .branch_en    (branch_en),
        .branch_addr  (branch_addr),
        .current_addr (current_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the rules in priority order, using plain integers.
    always @(posedge clk) begin
        if (rst) begin
            model_addr  = 0;
            model_valid = 1'b1;
        end else if (branch_en) begin
            model_addr = int'(branch_addr);
        end else if (inc) begin
            model_addr = (model_addr + 1) % ADDR_SPAN;
        end
    end

    // Continuous comparison, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (int'(current_addr) !== model_addr) begin
                errors++;
                $display("FAIL model_compare t=%0t actual=%0d expected=%0d",
                         $time, current_addr, model_addr);
            end
        end
    end

    // Apply one set of inputs across one rising edge, then settle.
    task automatic step(input logic r, input logic br, input int ba, input logic in);
        rst         = r;
        branch_en   = br;
        branch_addr = ba[ADDR_WIDTH-1:0];
        inc         = in;
        @(posedge clk);
        #1;
    endtask

    // Literal expectation: pins both the DUT and the model.
    task automatic expect_lit(input string name, input int value);
        checks++;
        if (int'(current_addr) !== value) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, current_addr, value);
        end
        checks++;
        if (model_addr != value) begin
            errors++;
            $display("FAIL %s_model actual=%0d expected=%0d", name, model_addr, value);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_addr  = 0;
        model_valid = 1'b0;
        rst         = 1'b1;
        inc         = 1'b1;
        branch_en   = 1'b1;
        branch_addr = 11'd55;

        // Reset dominates inc and branch for consecutive edges.
        step(1'b1, 1'b1, 55, 1'b1);  expect_lit("reset_edge1", 0);
        step(1'b1, 1'b1, 55, 1'b1);  expect_lit("reset_edge2", 0);

        // Sequential increment out of reset.
        step(1'b0, 1'b0, 0, 1'b1);   expect_lit("inc_1", 1);
        step(1'b0, 1'b0, 0, 1'b1);   expect_lit("inc_2", 2);
        step(1'b0, 1'b0, 0, 1'b1);   expect_lit("inc_3", 3);

        // Branch with inc high loads the target exactly.
        step(1'b1, 1'b0, 0, 1'b0);   expect_lit("reset_again", 0);
        step(1'b0, 1'b0, 0, 1'b1);   expect_lit("pre_branch", 1);
        step(1'b0, 1'b1, 20, 1'b1);  expect_lit("branch_20", 20);

        // Continue from target, then hold.
        step(1'b0, 1'b0, 0, 1'b1);   expect_lit("post_branch", 21);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 0, 1'b0);
            expect_lit("hold", 21);
        end

        // Wrap at the top of the range.
        step(1'b0, 1'b1, 2046, 1'b0); expect_lit("branch_2046", 2046);
        step(1'b0, 1'b0, 0, 1'b1);    expect_lit("inc_2047", 2047);
        step(1'b0, 1'b0, 0, 1'b1);    expect_lit("wrap_0", 0);

        // Reset in the middle of operation discards the branch.
        step(1'b0, 1'b1, 99, 1'b0);   expect_lit("branch_99", 99);
        step(1'b0, 1'b0, 0, 1'b1);    expect_lit("inc_100", 100);
        step(1'b1, 1'b1, 300, 1'b1);  expect_lit("reset_mid", 0);
        step(1'b0, 1'b0, 0, 1'b1);    expect_lit("after_reset_mid", 1);

        // Randomised traffic; targets biased toward the wrap boundary.
        for (int i = 0; i < 3000; i++) begin
            automatic int  sel = int'($urandom_range(0, 99));
            automatic int  ba  = ($urandom_range(0, 3) == 0)
                                 ? int'($urandom_range(ADDR_SPAN - 4, ADDR_SPAN - 1))
                                 : int'($urandom_range(0, ADDR_SPAN - 1));
            automatic logic r  = (sel < 3);
            automatic logic br = (sel >= 3 && sel < 18) || ($urandom_range(0, 9) == 0);
            automatic logic in = ($urandom_range(0, 3) != 0);
            step(r, br, ba, in);
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc_program_counter.md
# risc_program_counter

Program counter for the RISC core. It holds the 11-bit instruction address presented to instruction memory and updates once per clock. Each cycle it can reset, load a branch target, increment by one, or hold. The fetch stage reads the address combinationally from a register output; branch/jump control logic drives the load.

## Interface
Parameters:
- ADDR_WIDTH, 11, width of the address register, the branch target and the output.
- RESET_ADDR, 0, value loaded on reset; must fit in ADDR_WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset. Synchronous, active-high; sampled on the rising edge of clk.
- inc  input  1  increment enable; advances the address by 1 when no higher-priority action applies.
- branch_en  input  1  branch load enable.
- branch_addr  input  ADDR_WIDTH  branch target, loaded when branch_en is high.
- current_addr  output  ADDR_WIDTH  current program address, driven directly from the internal register.

## Operation
- A single ADDR_WIDTH-bit register drives current_addr. There is no combinational path from any input to current_addr.
- At each rising clk edge the register takes the first matching case, in strict priority order:
  1. rst = 1 → RESET_ADDR.
  2. branch_en = 1 → branch_addr. inc is ignored, and the register does not load branch_addr + 1.
  3. inc = 1 → current_addr + 1, modulo 2^ADDR_WIDTH.
  4. Otherwise → hold the current value.
- Arithmetic is unsigned. At the top of the range the increment wraps from 2047 to 0 (for ADDR_WIDTH = 11), with no flag and no saturation.
- branch_addr is loaded verbatim. There is no alignment check and no offset, so the block handles absolute addressing only.
- Reset during a branch or an increment: reset wins, and the load/increment in that cycle is discarded.
- Before the first reset, the register value is unspecified. Environments must assert rst for at least one rising edge before relying on current_addr. An FPGA power-up initial value of RESET_ADDR is permitted but not required.
- There is no internal state beyond the address register. The block has no handshake and no stall input; holding is done by keeping inc and branch_en low.

## Timing
- Latency is one cycle for every action. Inputs sampled at edge N appear on current_addr immediately after edge N and remain stable until edge N+1.
- Reset value: current_addr = RESET_ADDR (0) after the first edge with rst = 1. It stays at that value for every edge while rst remains high, regardless of inc and branch_en.
- First cycle after reset release, with inc = 1: the address becomes RESET_ADDR + 1 at the first edge where rst = 0.
- A branch followed by inc with branch_en low continues sequentially from the target: target, then target+1, target+2, and so on, one per edge.
- Simultaneous branch_en and inc in the same cycle: the register takes branch_addr exactly.
- Inputs must meet setup and hold relative to the rising edge of clk. There are no asynchronous paths.

## Test plan
- Reset: hold rst = 1 for two edges with inc = 1 and branch_en = 1 (branch_addr = 55). current_addr must be 0 after the first edge and still 0 after the second.
- Increment: release rst with inc = 1. Over consecutive edges current_addr must read 1, 2, 3.
- Branch with inc high: from reset, one increment edge gives 1. Then set branch_en = 1, branch_addr = 20, inc = 1. After the next edge current_addr must be 20, not 21.
- Post-branch sequencing and hold: drop branch_en with inc = 1, and current_addr must be 21 after one edge. Then set inc = 0 for three edges, and current_addr must stay 21 throughout.
- Wrap-around: branch to 2046, then increment with inc = 1. current_addr must read 2047 and then 0.
- Reset mid-operation: while incrementing at address 100, assert rst together with branch_en = 1, branch_addr = 300 for one edge. current_addr must be 0. After release with inc = 1, it must be 1 on the next edge.
